// File: rtl/uart_status_receiver.sv
// Receive side of the alarm status link: 8N1 UART deserialiser plus "STATUS:<WORD>;" frame parser.
// Optional inter-character timeout enabled by defining CMD_TIMEOUT_EN.
module uart_status_receiver #(
  parameter int unsigned CLK_FREQ  = 100000000,
  parameter int unsigned BAUD_RATE = 9600
`ifdef CMD_TIMEOUT_EN
  , parameter int unsigned TMO_BITS = 200
`endif
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_vld,
  output logic [2:0] o_status,
  output logic       o_valid,
  output logic       o_err,
  output logic       o_busy
);

  localparam int unsigned CPB  = CLK_FREQ / BAUD_RATE;
  localparam int unsigned HALF = CPB / 2;
  localparam int unsigned CW   = $clog2(CPB + 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {P_HUNT, P_PFX, P_PAY, P_DROP} p_state_t;

  rx_state_t       rstate;
  p_state_t        pstate;
  logic            rx_s1, rx_s2, rx_prev;
  logic [CW-1:0]   cnt;
  logic [2:0]      bitn;
  logic [7:0]      shreg;
  logic [2:0]      idx;
  logic [2:0]      len;
  logic [4:0][7:0] pay;
  logic            hit;
  logic [2:0]      code;

`ifdef CMD_TIMEOUT_EN
  localparam int unsigned TMO_CYC = TMO_BITS * CPB;
  localparam int unsigned TW      = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt;
`endif

  // Expected prefix character at each hunt position
  function automatic logic [7:0] pfx_char(input logic [2:0] i);
    case (i)
      3'd0:    pfx_char = "S";
      3'd1:    pfx_char = "T";
      3'd2:    pfx_char = "A";
      3'd3:    pfx_char = "T";
      3'd4:    pfx_char = "U";
      3'd5:    pfx_char = "S";
      default: pfx_char = ":";
    endcase
  endfunction

  // Payload word lookup; only exact-length matches count
  always_comb begin
    hit  = 1'b0;
    code = 3'b000;
    if (len == 3'd4 && {pay[0], pay[1], pay[2], pay[3]} == "OPEN") begin
      hit  = 1'b1;
      code = 3'b001;
    end else if (len == 3'd5 && {pay[0], pay[1], pay[2], pay[3], pay[4]} == "WRONG") begin
      hit  = 1'b1;
      code = 3'b010;
    end else if (len == 3'd4 && {pay[0], pay[1], pay[2], pay[3]} == "LOCK") begin
      hit  = 1'b1;
      code = 3'b100;
    end
  end

  assign o_busy = (pstate != P_HUNT) || (rstate != R_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      rstate     <= R_IDLE;
      pstate     <= P_HUNT;
      cnt        <= '0;
      bitn       <= '0;
      shreg      <= '0;
      idx        <= '0;
      len        <= '0;
      pay        <= '0;
      o_byte     <= '0;
      o_byte_vld <= 1'b0;
      o_status   <= '0;
      o_valid    <= 1'b0;
      o_err      <= 1'b0;
`ifdef CMD_TIMEOUT_EN
      tmo_cnt    <= '0;
`endif
    end else begin
      rx_s1      <= i_rx;
      rx_s2      <= rx_s1;
      rx_prev    <= rx_s2;
      o_byte_vld <= 1'b0;
      o_valid    <= 1'b0;
      o_err      <= 1'b0;

      // Bit-level receiver: mid-bit sampling from the synchronised line
      case (rstate)
        R_IDLE: begin
          if (rx_prev && !rx_s2) begin
            rstate <= R_START;
            cnt    <= '0;
          end
        end
        R_START: begin
          if (cnt == CW'(HALF - 1)) begin
            cnt  <= '0;
            bitn <= '0;
            rstate <= rx_s2 ? R_IDLE : R_DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        R_DATA: begin
          if (cnt == CW'(CPB - 1)) begin
            cnt   <= '0;
            shreg <= {rx_s2, shreg[7:1]};
            bitn  <= bitn + 3'd1;
            if (bitn == 3'd7) rstate <= R_STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (cnt == CW'(CPB - 1)) begin
            cnt    <= '0;
            rstate <= R_IDLE;
            if (rx_s2) begin
              o_byte     <= shreg;
              o_byte_vld <= 1'b1;
            end else begin
              o_err  <= 1'b1;
              pstate <= P_HUNT;
              idx    <= '0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      endcase

      // Frame parser, one byte per o_byte_vld
      if (o_byte_vld) begin
        case (pstate)
          P_HUNT, P_PFX: begin
            if (o_byte == pfx_char(idx)) begin
              if (idx == 3'd6) begin
                pstate <= P_PAY;
                idx    <= '0;
                len    <= '0;
              end else begin
                pstate <= P_PFX;
                idx    <= idx + 3'd1;
              end
            end else if (o_byte == "S") begin
              pstate <= P_PFX;
              idx    <= 3'd1;
            end else begin
              pstate <= P_HUNT;
              idx    <= '0;
            end
          end
          P_PAY: begin
            if (o_byte == ";") begin
              pstate <= P_HUNT;
              idx    <= '0;
              if (hit) begin
                o_status <= code;
                o_valid  <= 1'b1;
              end else begin
                o_err <= 1'b1;
              end
            end else if (len == 3'd5) begin
              pstate <= P_DROP;
              o_err  <= 1'b1;
            end else begin
              pay[len] <= o_byte;
              len      <= len + 3'd1;
            end
          end
          default: begin
            if (o_byte == ";") begin
              pstate <= P_HUNT;
              idx    <= '0;
            end
          end
        endcase
      end

`ifdef CMD_TIMEOUT_EN
      // Abandon a stalled partial frame
      if (o_byte_vld || pstate == P_HUNT) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TW'(TMO_CYC - 1)) begin
        tmo_cnt <= '0;
        pstate  <= P_HUNT;
        idx     <= '0;
        o_err   <= 1'b1;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
`endif
    end
  end

endmodule

// File: tb/tb_uart_status_receiver.sv
// Self-checking bench for uart_status_receiver (10 clocks per bit).
// Define CMD_TIMEOUT_EN to also exercise the inter-character timeout.
module tb_uart_status_receiver;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] byte_q;
  logic       byte_vld, valid, err, busy;
  logic [2:0] status;

  int n_chk  = 0;
  int n_fail = 0;
  int cnt_v  = 0;
  int cnt_e  = 0;
  int cnt_b  = 0;

  logic [7:0] exp_bytes[$];
  logic [2:0] exp_stat[$];

  always #5 clk = ~clk;

  uart_status_receiver #(
    .CLK_FREQ (1000000),
    .BAUD_RATE(100000)
`ifdef CMD_TIMEOUT_EN
    , .TMO_BITS(20)
`endif
  ) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_rx      (rx),
    .o_byte    (byte_q),
    .o_byte_vld(byte_vld),
    .o_status  (status),
    .o_valid   (valid),
    .o_err     (err),
    .o_busy    (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard: compare DUT output pulses against queued expectations
  always @(negedge clk) begin
    if (rst_n) begin
      if (byte_vld) begin
        cnt_b++;
        if (exp_bytes.size() == 0) chk("unexpected_byte", int'(byte_q), -1);
        else chk("byte", int'(byte_q), int'(exp_bytes.pop_front()));
      end
      if (valid) begin
        cnt_v++;
        if (exp_stat.size() == 0) chk("unexpected_valid", int'(status), -1);
        else chk("status_on_valid", int'(status), int'(exp_stat.pop_front()));
      end
      if (err) cnt_e++;
      if (valid && err) chk("valid_err_overlap", 1, 0);
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  function automatic int flen(input logic [127:0] t);
    for (int i = 15; i >= 0; i--)
      if (t[8*i +: 8] != 8'h00) return i + 1;
    return 0;
  endfunction

  task automatic send_str(input logic [127:0] t);
    int n;
    n = flen(t);
    for (int i = n - 1; i >= 0; i--) begin
      exp_bytes.push_back(t[8*i +: 8]);
      send_byte(t[8*i +: 8], 1'b1);
    end
  endtask

  task automatic settle(input string name);
    int k;
    repeat (5) @(negedge clk);
    k = 0;
    while (busy && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_idle"}, int'(busy), 0);
    repeat (3) @(negedge clk);
  endtask

  typedef struct packed {
    logic [127:0] txt;
    logic [2:0]   st;
    logic [1:0]   nv;
    logic [1:0]   ne;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int v0, e0, b0;
    #20000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0, b0;
    vecs[0] = '{128'("STATUS:OPEN;"),    3'b001, 2'd1, 2'd0};
    vecs[1] = '{128'("SSTATUS:LOCK;"),   3'b100, 2'd1, 2'd0};
    vecs[2] = '{128'("STATUS:OPENX;"),   3'b100, 2'd0, 2'd1};
    vecs[3] = '{128'("STATUS:WRONG;"),   3'b010, 2'd1, 2'd0};
    vecs[4] = '{128'("STATUS:;"),        3'b010, 2'd0, 2'd1};
    vecs[5] = '{128'("STATUS:TOOLONG;"), 3'b010, 2'd0, 2'd1};
    vecs[6] = '{128'("STATUS:LOK;"),     3'b010, 2'd0, 2'd1};
    vecs[7] = '{128'("STATUS;OPEN;"),    3'b010, 2'd0, 2'd0};
    vecs[8] = '{128'("XYSTATUS:LOCK;"),  3'b100, 2'd1, 2'd0};
    vecs[9] = '{128'("STATUS:open;"),    3'b100, 2'd0, 2'd1};

    repeat (4) @(negedge clk);
    chk("reset_status", int'(status), 0);
    chk("reset_byte_vld", int'(byte_vld), 0);
    chk("reset_valid", int'(valid), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_busy", int'(busy), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      v0 = cnt_v; e0 = cnt_e; b0 = cnt_b;
      if (vecs[i].nv != 0) exp_stat.push_back(vecs[i].st);
      send_str(vecs[i].txt);
      settle($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_bytes", i), cnt_b - b0, flen(vecs[i].txt));
      chk($sformatf("vec%0d_valid", i), cnt_v - v0, int'(vecs[i].nv));
      chk($sformatf("vec%0d_err", i), cnt_e - e0, int'(vecs[i].ne));
      chk($sformatf("vec%0d_status", i), int'(status), int'(vecs[i].st));
    end

    // Back-to-back frames without idle gap
    v0 = cnt_v; e0 = cnt_e;
    exp_stat.push_back(3'b010);
    exp_stat.push_back(3'b100);
    send_str(128'("STATUS:WRONG;"));
    send_str(128'("STATUS:LOCK;"));
    settle("b2b");
    chk("b2b_valid", cnt_v - v0, 2);
    chk("b2b_err", cnt_e - e0, 0);
    chk("b2b_status", int'(status), 3'b100);

    // Framing error, then recovery
    v0 = cnt_v; e0 = cnt_e; b0 = cnt_b;
    send_byte(8'h4F, 1'b0);
    settle("frm");
    chk("frm_bytes", cnt_b - b0, 0);
    chk("frm_err", cnt_e - e0, 1);
    exp_stat.push_back(3'b001);
    send_str(128'("STATUS:OPEN;"));
    settle("frm_rec");
    chk("frm_rec_status", int'(status), 3'b001);
    chk("frm_rec_valid", cnt_v - v0, 1);

    // Short low glitch on the line
    v0 = cnt_v; e0 = cnt_e; b0 = cnt_b;
    @(negedge clk);
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_bytes", cnt_b - b0, 0);
    chk("glitch_err", cnt_e - e0, 0);
    chk("glitch_busy", int'(busy), 0);

    // Reset in the middle of 'N' (bit 4), then a lone ';'
    send_str(128'("STATUS:OPE"));
    @(negedge clk);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = 1'(8'h4E >> i);
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_status", int'(status), 0);
    chk("midrst_busy", int'(busy), 0);
    repeat (20) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    v0 = cnt_v; e0 = cnt_e;
    send_str(128'(";"));
    settle("midrst");
    chk("midrst_valid", cnt_v - v0, 0);
    chk("midrst_err", cnt_e - e0, 0);
    exp_stat.push_back(3'b100);
    send_str(128'("STATUS:LOCK;"));
    settle("midrst_rec");
    chk("midrst_rec_valid", cnt_v - v0, 1);
    chk("midrst_rec_status", int'(status), 3'b100);

`ifdef CMD_TIMEOUT_EN
    // Stalled partial frame is abandoned after the timeout
    v0 = cnt_v; e0 = cnt_e;
    send_str(128'("STATUS:OP"));
    repeat (250) @(negedge clk);
    chk("tmo_err", cnt_e - e0, 1);
    chk("tmo_busy", int'(busy), 0);
    send_str(128'("EN;"));
    settle("tmo");
    chk("tmo_valid", cnt_v - v0, 0);
    chk("tmo_err_total", cnt_e - e0, 1);
    chk("tmo_status", int'(status), 3'b100);
`endif

    chk("bytes_left", exp_bytes.size(), 0);
    chk("status_left", exp_stat.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
